// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla_pkg
// Brief    : Shared width constant and group generate/propagate helpers for
//            the 4-bit lookahead slice and the higher lookahead levels.
// Revision : 1.0
// ============================================================================
package cla_pkg;

  localparam int CLA_W = 4;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Collapse four bit-level (or slice-level) g/p pairs into one group pair.
  function automatic gp_t cla_group(input logic [CLA_W-1:0] g, input logic [CLA_W-1:0] p);
    gp_t r;
    r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    r.p = &p;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cla_4b_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : cla_4b_adder_if
// Brief    : Operand, result and registered-result bundle of the 4-bit adder.
// Revision : 1.0
// ============================================================================
interface cla_4b_adder_if;
  import cla_pkg::*;

  logic [CLA_W-1:0] x;
  logic [CLA_W-1:0] y;
  logic             c_in;
  logic             en;
  logic [CLA_W-1:0] s;
  logic             c_out;
  logic             g;
  logic             p;
  logic             ovf;
  logic [CLA_W-1:0] s_q;
  logic             c_out_q;
  logic             g_q;
  logic             p_q;
  logic             ovf_q;

  modport master (
    output x, y, c_in, en,
    input  s, c_out, g, p, ovf, s_q, c_out_q, g_q, p_q, ovf_q
  );

  modport slave (
    input  x, y, c_in, en,
    output s, c_out, g, p, ovf, s_q, c_out_q, g_q, p_q, ovf_q
  );

endinterface
`default_nettype wire

// File: rtl/cla_4b_core.sv
`default_nettype none
// ============================================================================
// Module   : cla_4b_core
// Brief    : Purely combinational 4-bit flat carry-lookahead adder slice.
// Revision : 1.0
// ============================================================================
module cla_4b_core
  import cla_pkg::*;
(
  input  wire logic [CLA_W-1:0] i_x,
  input  wire logic [CLA_W-1:0] i_y,
  input  wire logic             i_c_in,
  output logic      [CLA_W-1:0] o_s,
  output logic                  o_c_out,
  output logic                  o_g,
  output logic                  o_p,
  output logic                  o_ovf
);

  logic [CLA_W-1:0] w_g;
  logic [CLA_W-1:0] w_p;
  logic [CLA_W-1:0] w_c;
  gp_t              w_gp;

  assign w_g = i_x & i_y;
  // XOR propagate keeps the group p exact for the next lookahead level.
  assign w_p = i_x ^ i_y;

  assign w_c[0] = i_c_in;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c_in);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c_in);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c_in);

  assign w_gp    = cla_group(w_g, w_p);

  assign o_s     = w_p ^ w_c;
  assign o_g     = w_gp.g;
  assign o_p     = w_gp.p;
  assign o_c_out = w_gp.g | (w_gp.p & i_c_in);
  assign o_ovf   = w_c[3] ^ o_c_out;

endmodule
`default_nettype wire

// File: rtl/cla_4b_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla_4b_adder
// Brief    : 4-bit CLA with zero-latency results plus an enable-gated register bank.
// Revision : 1.0
// ============================================================================
module cla_4b_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_W
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  cla_4b_adder_if.slave      bus
);

  logic [WIDTH-1:0] w_s;
  logic             w_c_out;
  logic             w_g;
  logic             w_p;
  logic             w_ovf;

  logic [WIDTH-1:0] r_s;
  logic             r_c_out;
  logic             r_g;
  logic             r_p;
  logic             r_ovf;

  cla_4b_core u_core (
    .i_x     (bus.x),
    .i_y     (bus.y),
    .i_c_in  (bus.c_in),
    .o_s     (w_s),
    .o_c_out (w_c_out),
    .o_g     (w_g),
    .o_p     (w_p),
    .o_ovf   (w_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s     <= '0;
      r_c_out <= 1'b0;
      r_g     <= 1'b0;
      r_p     <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (bus.en) begin
      r_s     <= w_s;
      r_c_out <= w_c_out;
      r_g     <= w_g;
      r_p     <= w_p;
      r_ovf   <= w_ovf;
    end
  end

  assign bus.s       = w_s;
  assign bus.c_out   = w_c_out;
  assign bus.g       = w_g;
  assign bus.p       = w_p;
  assign bus.ovf     = w_ovf;
  assign bus.s_q     = r_s;
  assign bus.c_out_q = r_c_out;
  assign bus.g_q     = r_g;
  assign bus.p_q     = r_p;
  assign bus.ovf_q   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cla_4b_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_4b_adder
// Brief    : Directed and exhaustive self-checking bench for cla_4b_adder.
// Revision : 1.0
// ============================================================================
module tb_cla_4b_adder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cla_4b_adder_if bus ();

  cla_4b_adder #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input logic [3:0] s, input logic c,
                         input logic g, input logic p, input logic v);
    check({tag, ".s_q"},     {4'h0, bus.s_q},     {4'h0, s});
    check({tag, ".c_out_q"}, {7'h0, bus.c_out_q}, {7'h0, c});
    check({tag, ".g_q"},     {7'h0, bus.g_q},     {7'h0, g});
    check({tag, ".p_q"},     {7'h0, bus.p_q},     {7'h0, p});
    check({tag, ".ovf_q"},   {7'h0, bus.ovf_q},   {7'h0, v});
  endtask

  task automatic check_c(input string tag, input logic [3:0] s, input logic c,
                         input logic g, input logic p, input logic v);
    check({tag, ".s"},     {4'h0, bus.s},     {4'h0, s});
    check({tag, ".c_out"}, {7'h0, bus.c_out}, {7'h0, c});
    check({tag, ".g"},     {7'h0, bus.g},     {7'h0, g});
    check({tag, ".p"},     {7'h0, bus.p},     {7'h0, p});
    check({tag, ".ovf"},   {7'h0, bus.ovf},   {7'h0, v});
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci);
    bus.x    = a;
    bus.y    = b;
    bus.c_in = ci;
    #1;
  endtask

  initial begin
    logic [4:0] sum;
    logic [4:0] gsum;
    logic       sovf;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.en = 1'b0;
    drive(4'h0, 4'h0, 1'b0);
    #11;
    check_q("reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Exhaustive sweep against an arithmetic reference.
    for (int i = 0; i < 512; i++) begin
      drive(i[8:5], i[4:1], i[0]);
      sum  = {1'b0, bus.x} + {1'b0, bus.y} + {4'h0, bus.c_in};
      gsum = {1'b0, bus.x} + {1'b0, bus.y};
      sovf = (bus.x[3] == bus.y[3]) && (sum[3] != bus.x[3]);
      check_c($sformatf("sweep%0d", i), sum[3:0], sum[4], gsum[4], &(bus.x ^ bus.y), sovf);
    end

    drive(4'hF, 4'hF, 1'b1);  check_c("FF1", 4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(4'hF, 4'h0, 1'b1);  check_c("F01", 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(4'h7, 4'h1, 1'b0);  check_c("710", 4'h8, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(4'h8, 4'h8, 1'b0);  check_c("880", 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(4'hA, 4'h5, 1'b0);  check_c("A50", 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(4'hA, 4'h5, 1'b1);  check_c("A51", 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Registered path.
    @(negedge clk);
    rst_n  = 1'b1;
    bus.en = 1'b1;
    drive(4'h5, 4'h3, 1'b1);
    @(negedge clk);
    check_q("load53", 4'h9, 1'b0, 1'b0, 1'b0, 1'b1);

    bus.en = 1'b0;
    drive(4'hF, 4'hF, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_q($sformatf("hold%0d", k), 4'h9, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    check_c("holdcomb", 4'hF, 1'b1, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_q("arst", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("arst.s", {4'h0, bus.s}, 8'h0F);
    drive(4'h1, 4'h2, 1'b0);
    check("arst.s2", {4'h0, bus.s}, 8'h03);
    bus.en = 1'b1;
    @(negedge clk);
    check_q("arst_en", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    rst_n = 1'b1;
    drive(4'h2, 4'h4, 1'b1);
    check_q("rel_noedge", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_q("rel_load", 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);

    drive(4'h8, 4'h8, 1'b0);
    @(negedge clk);
    check_q("load88", 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(4'hA, 4'h5, 1'b1);
    @(negedge clk);
    check_q("loadA5", 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
